// File: rtl/uart_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_checker
//
// Sequential receive-frame checker for the UART RX path. It takes mid-bit
// samples from the RX sampler and assembles DATA_WIDTH data bits LSB-first.
// It checks an optional parity bit under a parity mode latched at the start
// bit, and checks STOP_BITS stop bits. On completion it publishes the word and
// per-frame error flags for one frame_valid cycle. It also keeps two saturating
// error counters for the status registers.
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   STOP_BITS   stop bits checked per frame (1 or 2)
//   CNT_WIDTH   width of each saturating error counter
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous reset, active-low
//   start           1-cycle pulse, start bit validated by the sampler
//   bit_stb         1-cycle pulse, bit_in holds a new mid-bit sample
//   bit_in          sampled serial bit
//   parity_mode     000 none, 001 even, 010 odd, 011 mark, 100 space,
//                   101..111 none
//   err_clr         clears both error counters
//   data_out        last received word
//   frame_valid     1-cycle pulse, data_out and the flags were just updated
//   parity_err      parity error of the last completed frame
//   frame_err       stop-bit error of the last completed frame
//   busy            frame in progress
//   parity_err_cnt  saturating parity-error count
//   frame_err_cnt   saturating frame-error count, aborted frames included
// -----------------------------------------------------------------------------
module uart_rx_frame_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  bit_stb,
   input  logic                  bit_in,
   input  logic [2:0]            parity_mode,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  parity_err_cnt,
   output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   typedef enum logic [2:0] {
      PM_NONE  = 3'd0,
      PM_EVEN  = 3'd1,
      PM_ODD   = 3'd2,
      PM_MARK  = 3'd3,
      PM_SPACE = 3'd4
   } parity_mode_t;

   // One counter serves both the data-bit index and the stop-bit index.
   localparam int BC_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BC_W-1:0]      LAST_DATA = BC_W'(DATA_WIDTH - 1);
   localparam logic [BC_W-1:0]      LAST_STOP = BC_W'(STOP_BITS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   state_t                 state;
   logic [2:0]             mode_q;      // raw mode, so reserved codes stay representable
   logic [DATA_WIDTH-1:0]  shreg;
   logic [BC_W-1:0]        bit_cnt;
   logic                   par_err_q;   // parity result, held until completion
   logic                   stop_err_q;  // a zero seen on an earlier stop bit

   logic has_parity;
   logic exp_parity;
   logic stop_bad;
   logic abort;
   logic done;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      has_parity = 1'b0;
      exp_parity = 1'b0;
      case (mode_q)
         PM_EVEN:  begin has_parity = 1'b1; exp_parity = ^shreg;  end
         PM_ODD:   begin has_parity = 1'b1; exp_parity = ~^shreg; end
         PM_MARK:  begin has_parity = 1'b1; exp_parity = 1'b1;    end
         PM_SPACE: begin has_parity = 1'b1; exp_parity = 1'b0;    end
         default:  ;
      endcase
      stop_bad = stop_err_q | ~bit_in;
      abort    = start & (state != S_IDLE);
      // A start always wins over a coincident strobe, so it can never complete a frame.
      done     = ~start & bit_stb & (state == S_STOP) & (bit_cnt == LAST_STOP);
   end

   // NOTE: sequential state uses non-blocking assignments only. Reset is sampled
   // on the clock edge. The shift register is also cleared, so no stale data
   // from an earlier frame survives a reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         mode_q         <= PM_NONE;
         shreg          <= '0;
         bit_cnt        <= '0;
         par_err_q      <= 1'b0;
         stop_err_q     <= 1'b0;
         data_out       <= '0;
         frame_valid    <= 1'b0;
         parity_err     <= 1'b0;
         frame_err      <= 1'b0;
         busy           <= 1'b0;
         parity_err_cnt <= '0;
         frame_err_cnt  <= '0;
      end else begin
         frame_valid <= 1'b0;

         // A clear takes precedence over any increment in the same cycle.
         if (err_clr) begin
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
         end else begin
            if ((abort || (done && stop_bad)) && frame_err_cnt != CNT_MAX)
               frame_err_cnt <= frame_err_cnt + 1'b1;
            if (done && par_err_q && parity_err_cnt != CNT_MAX)
               parity_err_cnt <= parity_err_cnt + 1'b1;
         end

         if (start) begin
            // A fresh frame, or a restart that discards the one in progress.
            state      <= S_DATA;
            busy       <= 1'b1;
            mode_q     <= parity_mode;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
         end else if (bit_stb) begin
            case (state)
               S_DATA: begin
                  // Shift right so the first bit received ends up in bit 0.
                  shreg <= {bit_in, shreg[DATA_WIDTH-1:1]};
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= has_parity ? S_PARITY : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  par_err_q <= (bit_in != exp_parity);
                  state     <= S_STOP;
               end
               S_STOP: begin
                  if (bit_cnt == LAST_STOP) begin
                     state       <= S_IDLE;
                     busy        <= 1'b0;
                     frame_valid <= 1'b1;
                     data_out    <= shreg;
                     parity_err  <= par_err_q;
                     frame_err   <= stop_bad;
                     bit_cnt     <= '0;
                     stop_err_q  <= 1'b0;
                  end else begin
                     stop_err_q <= stop_bad;
                     bit_cnt    <= bit_cnt + 1'b1;
                  end
               end
               default: ;  // strobes in IDLE are ignored
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_checker
//
// Directed bench for uart_rx_frame_checker, configured with 8 data bits,
// 2 stop bits and 2-bit counters. A frame-level model collects the strobed
// bits of the current frame in a queue. When the queue holds a whole frame,
// the model derives the word, the parity result and the stop result
// arithmetically. A compare process checks every DUT output against the model
// on each falling edge. Literal expectations after key frames pin the model.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_checker;

   localparam int W    = 8;
   localparam int SB   = 2;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   localparam logic [2:0] M_NONE  = 3'd0;
   localparam logic [2:0] M_EVEN  = 3'd1;
   localparam logic [2:0] M_ODD   = 3'd2;
   localparam logic [2:0] M_MARK  = 3'd3;
   localparam logic [2:0] M_SPACE = 3'd4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          bit_stb = 1'b0;
   logic          bit_in = 1'b0;
   logic [2:0]    parity_mode = 3'd0;
   logic          err_clr = 1'b0;
   logic [W-1:0]  data_out;
   logic          frame_valid;
   logic          parity_err;
   logic          frame_err;
   logic          busy;
   logic [CW-1:0] parity_err_cnt;
   logic [CW-1:0] frame_err_cnt;

   uart_rx_frame_checker #(
      .DATA_WIDTH (W),
      .STOP_BITS  (SB),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .bit_stb        (bit_stb),
      .bit_in         (bit_in),
      .parity_mode    (parity_mode),
      .err_clr        (err_clr),
      .data_out       (data_out),
      .frame_valid    (frame_valid),
      .parity_err     (parity_err),
      .frame_err      (frame_err),
      .busy           (busy),
      .parity_err_cnt (parity_err_cnt),
      .frame_err_cnt  (frame_err_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit has_par(input logic [2:0] m);
      return (m >= 3'd1) && (m <= 3'd4);
   endfunction

   // ---------------- frame-level model ----------------
   bit         m_active = 1'b0;
   logic [2:0] m_mode   = 3'd0;
   bit         m_bits[$];
   logic [W-1:0] m_data = '0;
   bit         m_valid = 1'b0;
   bit         m_perr  = 1'b0;
   bit         m_ferr  = 1'b0;
   int         m_pcnt  = 0;
   int         m_fcnt  = 0;

   always @(posedge clk) begin
      bit aborted;
      aborted = 1'b0;
      if (!rst_n) begin
         m_active = 1'b0; m_mode = 3'd0; m_bits.delete();
         m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
         m_pcnt = 0; m_fcnt = 0;
      end else begin
         m_valid = 1'b0;
         if (start) begin
            aborted  = m_active;
            m_active = 1'b1;
            m_mode   = parity_mode;
            m_bits.delete();
         end else if (m_active && bit_stb) begin
            int need;
            m_bits.push_back(bit_in);
            need = W + (has_par(m_mode) ? 1 : 0) + SB;
            if (m_bits.size() == need) begin
               int ones;
               int exp_bit;
               m_data = '0;
               for (int i = 0; i < W; i++) m_data[i] = m_bits[i];
               ones = $countones(m_data);
               case (m_mode)
                  M_EVEN:  exp_bit = ones % 2;        // total ones including parity even
                  M_ODD:   exp_bit = 1 - (ones % 2);  // total ones including parity odd
                  M_MARK:  exp_bit = 1;
                  default: exp_bit = 0;               // space
               endcase
               m_perr = has_par(m_mode) ? (int'(m_bits[W]) != exp_bit) : 1'b0;
               m_ferr = 1'b0;
               for (int j = need - SB; j < need; j++) if (!m_bits[j]) m_ferr = 1'b1;
               m_valid  = 1'b1;
               m_active = 1'b0;
            end
         end
         if (err_clr) begin
            m_pcnt = 0;
            m_fcnt = 0;
         end else begin
            if (aborted || (m_valid && m_ferr)) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
            if (m_valid && m_perr)              m_pcnt = (m_pcnt < CMAX) ? m_pcnt + 1 : CMAX;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc data_out",       32'(data_out),       32'(m_data));
         check("cyc frame_valid",    32'(frame_valid),    32'(m_valid));
         check("cyc parity_err",     32'(parity_err),     32'(m_perr));
         check("cyc frame_err",      32'(frame_err),      32'(m_ferr));
         check("cyc busy",           32'(busy),           32'(m_active));
         check("cyc parity_err_cnt", 32'(parity_err_cnt), 32'(m_pcnt));
         check("cyc frame_err_cnt",  32'(frame_err_cnt),  32'(m_fcnt));
      end
   end

   // ---------------- stimulus ----------------
   // One call = one clock cycle of inputs, applied on the falling edge.
   task automatic drive(input logic s, input logic stb, input logic b,
                        input logic clr, input logic [2:0] pm);
      @(negedge clk);
      start = s; bit_stb = stb; bit_in = b; err_clr = clr; parity_mode = pm;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'($urandom()), 1'b0, 3'($urandom()));
   endtask

   // Full frame. The mode input wanders after the start cycle, which must have
   // no effect. Ends on the falling edge where frame_valid should be high.
   task automatic send_frame(input logic [2:0] mode, input logic [7:0] data, input logic par,
                             input logic [1:0] stops, input int gap,
                             input bit stb_on_start, input bit clr_last);
      drive(1'b1, stb_on_start, 1'b1, 1'b0, mode);
      for (int i = 0; i < W; i++) begin
         idle(gap);
         drive(1'b0, 1'b1, data[i], 1'b0, 3'($urandom()));
      end
      if (has_par(mode)) begin
         idle(gap);
         drive(1'b0, 1'b1, par, 1'b0, 3'($urandom()));
      end
      for (int j = 0; j < SB; j++) begin
         idle(gap);
         drive(1'b0, 1'b1, stops[j], clr_last && (j == SB - 1), 3'($urandom()));
      end
      idle(1);
   endtask

   task automatic partial(input logic [2:0] mode, input logic [7:0] data, input int nbits);
      drive(1'b1, 1'b0, 1'b0, 1'b0, mode);
      for (int i = 0; i < nbits; i++) drive(1'b0, 1'b1, data[i], 1'b0, 3'($urandom()));
      idle(1);
   endtask

   initial begin
      int exp5[5];
      exp5 = '{1, 2, 3, 3, 3};

      // Reset
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      check("rst busy", 32'(busy), 0);
      check("rst data_out", 32'(data_out), 0);
      check("rst cnts", 32'({parity_err_cnt, frame_err_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Strobes in IDLE are ignored
      drive(1'b0, 1'b1, 1'b1, 1'b0, M_EVEN);
      drive(1'b0, 1'b1, 1'b0, 1'b0, M_EVEN);
      idle(1);
      check("idle stb busy", 32'(busy), 0);

      // 1: even, 0xA5 has four ones -> parity bit 0
      send_frame(M_EVEN, 8'hA5, 1'b0, 2'b11, 0, 0, 0);
      check("t1 frame_valid", 32'(frame_valid), 1);
      check("t1 data_out", 32'(data_out), 32'h0A5);
      check("t1 errs", 32'({parity_err, frame_err}), 0);
      check("t1 busy", 32'(busy), 0);
      idle(1);
      check("t1 valid one cycle", 32'(frame_valid), 0);

      // 2: odd wants ~^data; 0x01 has one 1, so expected parity bit is 0
      send_frame(M_ODD, 8'h01, 1'b1, 2'b11, 1, 0, 0);
      check("t2a parity_err", 32'(parity_err), 1);
      check("t2a pcnt", 32'(parity_err_cnt), 1);
      send_frame(M_ODD, 8'h01, 1'b0, 2'b11, 0, 0, 0);
      check("t2b parity_err", 32'(parity_err), 0);
      check("t2b pcnt", 32'(parity_err_cnt), 1);

      // 3: no parity, second stop bit low
      send_frame(M_NONE, 8'h3C, 1'b0, 2'b01, 0, 0, 0);
      check("t3 frame_err", 32'(frame_err), 1);
      check("t3 fcnt", 32'(frame_err_cnt), 1);
      check("t3 data_out", 32'(data_out), 32'h03C);

      // 4: restart after 4 data bits; new start arrives with a coincident strobe
      partial(M_NONE, 8'hFF, 4);
      check("t4 busy mid", 32'(busy), 1);
      send_frame(M_NONE, 8'h5A, 1'b0, 2'b11, 2, 1, 0);
      check("t4 fcnt", 32'(frame_err_cnt), 2);
      check("t4 data_out", 32'(data_out), 32'h05A);
      check("t4 frame_err", 32'(frame_err), 0);

      // Reserved mode code behaves as no parity
      send_frame(3'b110, 8'hC3, 1'b0, 2'b11, 0, 0, 0);
      check("rsv data_out", 32'(data_out), 32'h0C3);
      check("rsv frame_valid", 32'(frame_valid), 1);

      // 5: clear, then saturate the parity counter (0x03 even wants 0)
      drive(1'b0, 1'b0, 1'b0, 1'b1, M_NONE);
      idle(1);
      check("t5 cleared", 32'({parity_err_cnt, frame_err_cnt}), 0);
      for (int k = 0; k < 5; k++) begin
         send_frame(M_EVEN, 8'h03, 1'b1, 2'b11, 0, 0, 0);
         check("t5 pcnt sat", 32'(parity_err_cnt), 32'(exp5[k]));
      end
      send_frame(M_EVEN, 8'h03, 1'b1, 2'b11, 0, 0, 1);
      check("t5 clr wins", 32'(parity_err_cnt), 0);
      check("t5 flag kept", 32'(parity_err), 1);

      // Frame counter saturation
      for (int k = 0; k < 4; k++) send_frame(M_NONE, 8'h81, 1'b0, 2'b00, 0, 0, 0);
      check("fcnt sat", 32'(frame_err_cnt), 3);

      // Space mode: expected 0, sent 1
      send_frame(M_SPACE, 8'h10, 1'b1, 2'b11, 1, 0, 0);
      check("space parity_err", 32'(parity_err), 1);

      // 6: reset mid-DATA
      partial(M_EVEN, 8'hFF, 3);
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; bit_stb = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6 busy", 32'(busy), 0);
      check("t6 outs", 32'({data_out, parity_err, frame_err, frame_valid}), 0);
      check("t6 cnts", 32'({parity_err_cnt, frame_err_cnt}), 0);
      send_frame(M_MARK, 8'h77, 1'b1, 2'b11, 0, 0, 0);
      check("t6 mark parity_err", 32'(parity_err), 0);
      check("t6 data_out", 32'(data_out), 32'h077);

      idle(3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
